mem_arbiter: RTL and testbench

// Shares one unified memory port between the cpu fetch path (pc/inst) and the
// MEM-stage data path (address/store_data/load_data). One transaction in flight.

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter_if.sv | 43 ++++
 rtl/mem_arb_pick.sv | 29 ++
 rtl/mem_arbiter.sv | 112 +++++++++++
 tb/tb_mem_arbiter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the unified-memory arbiter.
//   arb_state_e : arbiter FSM states (idle / request issued / awaiting read data)
//   owner_e     : which requester owns the transaction in flight
//   streak_width: counter width able to hold 0..max inclusive
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ArbIdle  = 2'd0,
        ArbIssue = 2'd1,
        ArbWait  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OwnFetch = 1'b0,
        OwnData  = 1'b1
    } owner_e;

    function automatic int unsigned streak_width(input int unsigned max_streak);
        return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of all handshake/bus signals around the arbiter.
//   if_*  : cpu fetch port (req/addr in, gnt/rvalid/rdata out)
//   d_*   : MEM-stage data port (req/we/addr/wdata in, gnt/rvalid/rdata out)
//   m_*   : single-ported memory side (req/we/addr/wdata out, ready/rvalid/rdata in)
// Modport slave is the arbiter's view; master is the view of the core plus memory.
interface mem_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_gnt;
    logic            if_rvalid;
    logic [XLEN-1:0] if_rdata;

    logic            d_req;
    logic            d_we;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic            d_gnt;
    logic            d_rvalid;
    logic [XLEN-1:0] d_rdata;

    logic            m_req;
    logic            m_we;
    logic [XLEN-1:0] m_addr;
    logic [XLEN-1:0] m_wdata;
    logic            m_ready;
    logic            m_rvalid;
    logic [XLEN-1:0] m_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_ready, m_rvalid, m_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output m_req, m_we, m_addr, m_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_ready, m_rvalid, m_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  m_req, m_we, m_addr, m_wdata
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and data requests.
//   if_req, d_req : pending requests
//   streak        : consecutive data wins while fetch has been waiting
//   valid         : at least one request pending
//   owner         : winner (data by default; fetch once the streak hits MAX_D_STREAK)
module mem_arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned SW           = streak_width(MAX_D_STREAK)
) (
    input  logic          if_req,
    input  logic          d_req,
    input  logic [SW-1:0] streak,
    output logic          valid,
    output owner_e        owner
);

    localparam logic [SW-1:0] StreakMax = SW'(MAX_D_STREAK);

    logic fetch_starved;

    always_comb begin
        fetch_starved = if_req && (streak == StreakMax);
        valid         = if_req || d_req;
        owner         = (d_req && !fetch_starved) ? OwnData : OwnFetch;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the fetch path and the MEM-stage data path.
// One transaction in flight; data has priority, limited by a fetch anti-starvation streak.
//   clock, reset : system clock, synchronous active-high reset
//   bus          : all fetch/data/memory handshake signals (slave view)
//   busy         : high whenever a transaction is in flight (core stall hint)
// Grants pulse combinationally in the cycle memory accepts; read data is steered
// combinationally to the owner in the cycle m_rvalid arrives.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus,
    output logic          busy
);

    localparam int unsigned     SW        = streak_width(MAX_D_STREAK);
    localparam logic [SW-1:0]   StreakMax = SW'(MAX_D_STREAK);

    arb_state_e      state;
    owner_e          owner;
    logic [SW-1:0]   streak;

    logic            pick_valid;
    owner_e          pick_owner;
    logic            accept;
    logic            respond;
    logic [XLEN-1:0] rdata;

    mem_arb_pick #(
        .MAX_D_STREAK (MAX_D_STREAK),
        .SW           (SW)
    ) u_pick (
        .if_req (bus.if_req),
        .d_req  (bus.d_req),
        .streak (streak),
        .valid  (pick_valid),
        .owner  (pick_owner)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ArbIdle;
            owner       <= OwnFetch;
            streak      <= '0;
            bus.m_req   <= 1'b0;
            bus.m_we    <= 1'b0;
            bus.m_addr  <= '0;
            bus.m_wdata <= '0;
        end else begin
            case (state)
                ArbIdle: begin
                    if (pick_valid) begin
                        owner     <= pick_owner;
                        bus.m_req <= 1'b1;
                        state     <= ArbIssue;
                        if (pick_owner == OwnData) begin
                            bus.m_we    <= bus.d_we;
                            bus.m_addr  <= bus.d_addr;
                            bus.m_wdata <= bus.d_wdata;
                        end else begin
                            bus.m_we    <= 1'b0;
                            bus.m_addr  <= bus.if_addr;
                        end
                    end
                    // Streak only counts data wins that made a waiting fetch wait longer.
                    if (bus.if_req && pick_owner == OwnData) begin
                        if (streak != StreakMax) begin
                            streak <= streak + SW'(1);
                        end
                    end else begin
                        streak <= '0;
                    end
                end
                ArbIssue: begin
                    if (bus.m_ready) begin
                        bus.m_req <= 1'b0;
                        // Stores are posted: done once memory accepts them.
                        state     <= bus.m_we ? ArbIdle : ArbWait;
                    end
                end
                ArbWait: begin
                    if (bus.m_rvalid) begin
                        state <= ArbIdle;
                    end
                end
                default: begin
                    state     <= ArbIdle;
                    bus.m_req <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        // Pulses are suppressed while reset is held so an abandoned transaction stays silent.
        accept        = (state == ArbIssue) && bus.m_ready && !reset;
        respond       = (state == ArbWait) && bus.m_rvalid && !reset;
        rdata         = bus.m_rdata;
        bus.if_gnt    = accept && (owner == OwnFetch);
        bus.d_gnt     = accept && (owner == OwnData);
        bus.if_rvalid = respond && (owner == OwnFetch);
        bus.d_rvalid  = respond && (owner == OwnData);
        bus.if_rdata  = rdata;
        bus.d_rdata   = rdata;
        busy          = (state != ArbIdle);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model predicts every output each
// cycle, and literal expectations pin the model on the documented scenarios.
module tb_mem_arbiter;

    localparam int MAX = 4;

    logic clk = 1'b0;
    logic reset;
    logic busy;

    int vectors = 0;
    int fails   = 0;

    mem_arbiter_if #(.XLEN(32)) b ();

    mem_arbiter #(
        .XLEN         (32),
        .MAX_D_STREAK (MAX)
    ) dut (
        .clock (clk),
        .reset (reset),
        .bus   (b),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one transaction record (owner, kind, address, data) plus its progress.
    bit          t_open;      // a transaction is in flight
    bit          t_taken;     // memory has accepted it (read awaiting data)
    bit          t_data;      // owner is the data side
    bit          t_we;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;
    int          d_run;       // data wins in a row while fetch was waiting
    logic        want_data;

    assign want_data = b.d_req && (!b.if_req || d_run < MAX);

    always @(posedge clk) begin
        if (reset) begin
            t_open <= 0; t_taken <= 0; d_run <= 0;
            t_we <= 0; t_addr <= 0; t_wdata <= 0;
        end else if (!t_open) begin
            if (b.if_req || b.d_req) begin
                t_open  <= 1;
                t_taken <= 0;
                t_data  <= want_data;
                t_we    <= want_data ? b.d_we : 1'b0;
                t_addr  <= want_data ? b.d_addr : b.if_addr;
                if (want_data) t_wdata <= b.d_wdata;
            end
            d_run <= (b.if_req && want_data) ? ((d_run < MAX) ? d_run + 1 : d_run) : 0;
        end else if (!t_taken) begin
            if (b.m_ready) begin
                if (t_we) t_open <= 0;
                else      t_taken <= 1;
            end
        end else if (b.m_rvalid) begin
            t_open <= 0;
        end
    end

    bit    log_en = 0;
    string glog   = "";

    always @(negedge clk) begin
        logic offer, ret;
        offer = t_open && !t_taken && b.m_ready && !reset;
        ret   = t_open && t_taken && b.m_rvalid && !reset;
        check("if_gnt",    b.if_gnt,    offer && !t_data);
        check("d_gnt",     b.d_gnt,     offer && t_data);
        check("if_rvalid", b.if_rvalid, ret && !t_data);
        check("d_rvalid",  b.d_rvalid,  ret && t_data);
        check("busy",      busy,        t_open);
        check("m_req",     b.m_req,     t_open && !t_taken);
        if (t_open && !t_taken) begin
            check("m_addr", b.m_addr, t_addr);
            check("m_we",   b.m_we,   t_we);
            if (t_we) check("m_wdata", b.m_wdata, t_wdata);
        end
        if (ret && !t_data) check("if_rdata", b.if_rdata, b.m_rdata);
        if (ret && t_data)  check("d_rdata",  b.d_rdata,  b.m_rdata);
        if (log_en && b.d_gnt)  glog <= {glog, "D"};
        if (log_en && b.if_gnt) glog <= {glog, "F"};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        string order;
        reset = 1;
        b.if_req = 0; b.if_addr = 0;
        b.d_req = 0; b.d_we = 0; b.d_addr = 0; b.d_wdata = 0;
        b.m_ready = 0; b.m_rvalid = 0; b.m_rdata = 0;
        tick(); tick();
        sample();
        check("rst m_req",   b.m_req,   0);
        check("rst m_we",    b.m_we,    0);
        check("rst m_addr",  b.m_addr,  0);
        check("rst m_wdata", b.m_wdata, 0);
        check("rst busy",    busy,      0);
        tick(); reset = 0;

        // 1: fetch only
        tick(); b.if_req = 1; b.if_addr = 32'h100; b.m_ready = 1;
        tick(); sample();
        check("t1 m_addr", b.m_addr, 32'h100);
        check("t1 m_we",   b.m_we,   0);
        check("t1 if_gnt", b.if_gnt, 1);
        tick(); b.if_req = 0; b.m_ready = 0;
        sample(); check("t1 busy wait", busy, 1);
        tick(); b.m_rvalid = 1; b.m_rdata = 32'h0000_0013;
        sample();
        check("t1 if_rvalid", b.if_rvalid, 1);
        check("t1 if_rdata",  b.if_rdata,  32'h13);
        tick(); b.m_rvalid = 0;
        sample(); check("t1 busy T4", busy, 0);

        // 2: posted store
        tick(); b.d_req = 1; b.d_we = 1; b.d_addr = 32'h2000; b.d_wdata = 32'hDEAD_BEEF;
        b.m_ready = 1;
        tick(); sample();
        check("t2 m_we",    b.m_we,    1);
        check("t2 m_wdata", b.m_wdata, 32'hDEAD_BEEF);
        check("t2 d_gnt",   b.d_gnt,   1);
        tick(); b.d_req = 0; b.d_we = 0;
        sample();
        check("t2 busy",     busy,       0);
        check("t2 d_rvalid", b.d_rvalid, 0);

        // 3: contention with instant ready/rvalid
        tick(); b.if_req = 1; b.d_req = 1; b.if_addr = 32'h300; b.d_addr = 32'h400;
        b.m_ready = 1; b.m_rvalid = 1; b.m_rdata = 32'h55; log_en = 1;
        for (int i = 0; i < 30; i++) tick();
        b.if_req = 0; b.d_req = 0; b.m_rvalid = 0; b.m_ready = 0;
        log_en = 0;
        order = "DDDDFDDDDF";
        check("t3 grants", glog.len(), 10);
        for (int i = 0; i < 10 && i < glog.len(); i++) begin
            check($sformatf("t3 grant%0d", i), 32'(glog[i]), 32'(order[i]));
        end
        tick(); tick(); tick();

        // 4: backpressure on a store
        tick(); b.d_req = 1; b.d_we = 1; b.d_addr = 32'h3000; b.d_wdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            tick(); sample();
            check("t4 m_addr",  b.m_addr,  32'h3000);
            check("t4 m_we",    b.m_we,    1);
            check("t4 m_wdata", b.m_wdata, 32'h1234_5678);
            check("t4 no gnt",  b.d_gnt,   0);
        end
        tick(); b.m_ready = 1;
        sample(); check("t4 d_gnt", b.d_gnt, 1);
        tick(); b.d_req = 0; b.d_we = 0; b.m_ready = 0;
        sample(); check("t4 idle", busy, 0);

        // 5: reset while waiting for load data
        tick(); b.d_req = 1; b.d_addr = 32'h44; b.m_ready = 1;
        tick(); sample(); check("t5 d_gnt", b.d_gnt, 1);
        tick(); b.d_req = 0; b.m_ready = 0; reset = 1;
        sample(); check("t5 busy in wait", busy, 1);
        tick(); reset = 0;
        sample();
        check("t5 m_req", b.m_req, 0);
        check("t5 busy",  busy,    0);
        tick(); b.m_rvalid = 1; b.m_rdata = 32'hAAAA_AAAA;
        sample();
        check("t5 d_rvalid",  b.d_rvalid,  0);
        check("t5 if_rvalid", b.if_rvalid, 0);
        tick(); b.m_rvalid = 0;

        // 6: spurious m_rvalid in idle
        tick(); b.m_rvalid = 1; b.m_rdata = 32'hFFFF_FFFF;
        sample();
        check("t6 if_rvalid", b.if_rvalid, 0);
        check("t6 d_rvalid",  b.d_rvalid,  0);
        tick(); sample();
        check("t6 busy", busy, 0);
        tick(); b.m_rvalid = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
